// File: rtl/pwm_servo_out.sv
// Frame-synchronous servo PWM regenerator with per-frame command latch, slew limit, watchdog failsafe and enable gate.
// Outputs are registered; a new command appears at the next frame start. There is no backpressure: cmd_valid is sampled every cycle.
module pwm_servo_out #(
  parameter int PERIOD_US      = 20000,
  parameter int MIN_US         = 988,
  parameter int FS_CMD         = 0,
  parameter int TIMEOUT_FRAMES = 5,
  parameter int MAX_STEP       = 1023
) (
  input  logic        clk_1M,
  input  logic        rst,
  input  logic [9:0]  cmd,
  input  logic        cmd_valid,
  input  logic        enable,
  output logic        pwm,
  output logic        frame_start,
  output logic        failsafe,
  output logic [11:0] width_us
);
  localparam int              CW   = $clog2(PERIOD_US);
  localparam int              MW   = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0]   LAST = CW'(PERIOD_US - 1);
  localparam logic [9:0]      FS   = 10'(FS_CMD);
  localparam logic [MW-1:0]   TMO  = MW'(TIMEOUT_FRAMES);
  localparam logic [10:0]     STEP = 11'(MAX_STEP);
  localparam logic [11:0]     MINW = 12'(MIN_US);

  typedef enum logic [1:0] {
    ST_FAILSAFE = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DISABLED = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic [9:0]    r_pending;
  logic          r_seen;
  logic [MW-1:0] r_miss;
  logic [9:0]    r_applied;

  logic          w_boundary;
  logic [CW-1:0] w_cnt_nxt;
  logic [9:0]    w_pending;
  logic          w_seen;
  logic [MW-1:0] w_miss_nxt;
  state_t        w_state_nxt;
  logic [10:0]   w_diff;
  logic [10:0]   w_mag;
  logic [9:0]    w_slew;
  logic [9:0]    w_applied_nxt;
  logic [11:0]   w_width_nxt;

  // r_run holds the counter at 0 for the first cycle out of reset so that cycle is a frame start.
  assign w_boundary = r_run && (r_cnt == LAST);
  assign w_cnt_nxt  = (!r_run || w_boundary) ? '0 : r_cnt + 1'b1;
  assign w_pending  = cmd_valid ? cmd : r_pending;
  assign w_seen     = r_seen | cmd_valid;
  assign w_miss_nxt = w_seen ? '0 : ((r_miss == TMO) ? TMO : r_miss + 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_DISABLED;
    end else if (w_boundary) begin
      case (r_state)
        ST_DISABLED: w_state_nxt = ST_FAILSAFE;
        ST_FAILSAFE: if (w_miss_nxt == '0) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE:   if (w_miss_nxt == TMO) w_state_nxt = ST_FAILSAFE;
        default:     w_state_nxt = ST_FAILSAFE;
      endcase
    end
  end

  always_comb begin
    w_diff = {1'b0, w_pending} - {1'b0, r_applied};
    w_mag  = w_diff[10] ? (~w_diff + 11'd1) : w_diff;
    w_slew = w_pending;
    if (w_mag > STEP) begin
      w_slew = w_diff[10] ? (r_applied - STEP[9:0]) : (r_applied + STEP[9:0]);
    end
  end

  assign w_applied_nxt = !w_boundary ? r_applied
                       : ((w_state_nxt == ST_ACTIVE) ? w_slew : FS);
  assign w_width_nxt   = MINW + {2'b00, w_applied_nxt};

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      r_state     <= ST_FAILSAFE;
      r_cnt       <= '0;
      r_run       <= 1'b0;
      r_pending   <= FS;
      r_seen      <= 1'b0;
      r_miss      <= TMO;
      r_applied   <= FS;
      pwm         <= 1'b0;
      frame_start <= 1'b0;
      failsafe    <= 1'b1;
      width_us    <= MINW + {2'b00, FS};
    end else begin
      r_run       <= 1'b1;
      r_cnt       <= w_cnt_nxt;
      r_pending   <= w_pending;
      r_seen      <= w_boundary ? 1'b0 : w_seen;
      if (w_boundary) r_miss <= w_miss_nxt;
      r_state     <= w_state_nxt;
      r_applied   <= w_applied_nxt;
      width_us    <= w_width_nxt;
      failsafe    <= (w_state_nxt != ST_ACTIVE);
      frame_start <= (w_cnt_nxt == '0);
      pwm         <= (w_state_nxt != ST_DISABLED) &&
                     ({{(32-CW){1'b0}}, w_cnt_nxt} < {20'd0, w_width_nxt});
    end
  end
endmodule
